stage_cp_buffer: RTL
====================

Name: stage_cp_buffer

Overview:
- Completion-stage buffer directly downstream of the execute stage.
- Captures one execute result per cycle into a small in-order FIFO.
- Broadcasts one entry per cycle on the common data bus (CDB) to the ROB, RS and map table.
- Back-pressures execute when full; is cleared by a branch-mispredict flush from retire.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PREG_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  mispredict squash from retire; synchronous clear.
- ex_valid  in  1  execute stage presents a result this cycle.
- ex_ready  out  1  buffer accepts this cycle; equals (count != DEPTH).
- ex_result  in  XLEN  ALU/mult/load result.
- ex_npc  in  XLEN  next PC of the instruction.
- ex_take_branch  in  1  resolved branch taken.
- ex_dest_valid  in  1  instruction writes a physical register.
- ex_dest_tag  in  PREG_W  destination physical register.
- ex_rob_idx  in  ROB_W  ROB slot of the instruction.
- ex_halt  in  1  halt instruction.
- ex_illegal  in  1  illegal instruction.
- cdb_ready  in  1  ROB/CDB can take a broadcast this cycle.
- cdb_valid  out  1  head entry is being broadcast.
- cdb_result, cdb_npc  out  XLEN each  head fields.
- cdb_take_branch, cdb_dest_valid, cdb_halt, cdb_illegal  out  1 each  head fields.
- cdb_dest_tag  out  PREG_W  head tag; forced to 0 when cdb_dest_valid=0.
- cdb_rob_idx  out  ROB_W  head ROB index.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: entry array, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count register.
- Reset: head=tail=count=0; entry storage contents are don't-care.
  - Output reset values: cdb_valid=0, all cdb_* fields=0 (fields are masked with cdb_valid), ex_ready=1, count=0.
- Enqueue (enq) = ex_valid && ex_ready && !flush.
  - Writes the entry at tail; tail increments.
  - ex_valid while ex_ready=0 is not lost: execute holds its packet until accepted.
- Dequeue (deq) = cdb_valid && cdb_ready && !flush.
  - head increments.
- cdb_valid = (count != 0), combinational from registered state.
  - cdb_* fields are driven from the head entry; zero when cdb_valid=0.
  - Fields are stable while cdb_valid=1 and cdb_ready=0.
- Latency: a result enqueued in cycle N appears on the CDB in cycle N+1 at the earliest. There is no same-cycle bypass.
- Occupancy: count_next = count + enq - deq.
  - Empty with enq and no deq: count becomes 1.
  - Full: enq is impossible because ex_ready=0; deq frees a slot, and ex_ready rises the following cycle.
  - Simultaneous enq and deq at 0 < count < DEPTH: count unchanged; both pointers advance.
- Ordering: strict FIFO. Pointer wrap from DEPTH-1 to 0 keeps that order.
- Flush:
  - Next edge sets head=tail=count=0; enq and deq are suppressed that cycle.
  - cdb_valid is 0 in the cycle after flush.
  - Flush takes priority over every other event.
- Asynchronous reset asserted mid-operation: state and outputs go to reset values immediately, without waiting for a clock edge.
- A dest tag of 0 (x0) is broadcast with cdb_dest_valid forced to 0.

Test Plan:
- Reset, then ex_valid=1 for one cycle (result=0x11, tag=5, rob=3) with cdb_ready=1 -> next cycle cdb_valid=1, cdb_result=0x11, cdb_dest_tag=5, cdb_rob_idx=3; the cycle after that, cdb_valid=0, count=0.
- cdb_ready=0, five back-to-back enqueues with results 1..5 -> ex_ready=0 after the 4th accept and count=4; result 5 is held by execute. cdb_ready=1 -> broadcasts 1,2,3,4,5 in order, with 5 accepted the cycle after ex_ready returns to 1.
- Steady stream with ex_valid=1 and cdb_ready=1 for 10 cycles -> count holds at 1, one broadcast per cycle, and pointer wrap past index 3 keeps order.
- Fill 3 entries, assert flush with ex_valid=1 -> the next cycle has count=0 and cdb_valid=0, and the flushed-cycle input is not enqueued.
- Enqueue a halt with dest_valid=1 and tag=0 -> cdb_halt=1, cdb_dest_valid=0, cdb_dest_tag=0.
- Assert reset asynchronously between clock edges with 2 entries held -> cdb_valid=0 and count=0 before the next rising edge.

Source files
------------

// File: rtl/stage_cp_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stage_cp_buffer
// Purpose  : Completion-stage buffer sitting right after execute. Captures at
//            most one execute result per cycle into a small in-order FIFO and
//            broadcasts the oldest entry on the common data bus (CDB) toward
//            the ROB, reservation stations and map table. Back-pressures
//            execute when full; a mispredict flush from retire empties it.
// Ports    :
//   clock, reset            system clock; asynchronous active-high reset
//   flush                   synchronous squash, highest priority
//   ex_valid / ex_ready     execute-side handshake (ready = not full)
//   ex_result, ex_npc       execute data fields
//   ex_take_branch, ex_dest_valid, ex_dest_tag, ex_rob_idx,
//   ex_halt, ex_illegal     execute control fields
//   cdb_ready / cdb_valid   CDB-side handshake (valid = not empty)
//   cdb_*                   head-entry fields, zeroed while cdb_valid=0
//   count                   current occupancy (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module stage_cp_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [XLEN-1:0]            ex_result,
  input  logic [XLEN-1:0]            ex_npc,
  input  logic                       ex_take_branch,
  input  logic                       ex_dest_valid,
  input  logic [PREG_W-1:0]          ex_dest_tag,
  input  logic [ROB_W-1:0]           ex_rob_idx,
  input  logic                       ex_halt,
  input  logic                       ex_illegal,
  input  logic                       cdb_ready,
  output logic                       cdb_valid,
  output logic [XLEN-1:0]            cdb_result,
  output logic [XLEN-1:0]            cdb_npc,
  output logic                       cdb_take_branch,
  output logic                       cdb_dest_valid,
  output logic [PREG_W-1:0]          cdb_dest_tag,
  output logic [ROB_W-1:0]           cdb_rob_idx,
  output logic                       cdb_halt,
  output logic                       cdb_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   npc;
    logic              take_branch;
    logic              dest_valid;
    logic [PREG_W-1:0] dest_tag;
    logic [ROB_W-1:0]  rob_idx;
    logic              halt;
    logic              illegal;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_head;
  logic [C_PTR_W-1:0]   r_tail;
  logic [C_CNT_W-1:0]   r_count;
  logic [C_CNT_W-1:0]   w_count_next;
  logic                 w_enq;
  logic                 w_deq;
  entry_t               w_in;
  entry_t               w_head;
  logic                 w_head_writes;

  // Handshakes. Flush masks both sides so nothing moves in a squash cycle.
  assign ex_ready  = (r_count != C_CNT_W'(DEPTH));
  assign cdb_valid = (r_count != '0);
  assign w_enq     = ex_valid && ex_ready && !flush;
  assign w_deq     = cdb_valid && cdb_ready && !flush;

  assign w_in = '{
    result:      ex_result,
    npc:         ex_npc,
    take_branch: ex_take_branch,
    dest_valid:  ex_dest_valid,
    dest_tag:    ex_dest_tag,
    rob_idx:     ex_rob_idx,
    halt:        ex_halt,
    illegal:     ex_illegal
  };

  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + C_CNT_W'(1);
      2'b01:   w_count_next = r_count - C_CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers and occupancy. DEPTH is a power of two, so the natural
  // wrap of the pointer width gives modulo-DEPTH indexing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + C_PTR_W'(1);
      if (w_deq) r_head <= r_head + C_PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Entry storage needs no reset: it is only observed through count.
  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_tail] <= w_in;
  end

  assign w_head = r_mem[r_head];

  // Physical register 0 is hard-wired, so a write to it is never broadcast
  // as a real destination.
  assign w_head_writes = w_head.dest_valid && (w_head.dest_tag != '0);

  assign cdb_result      = cdb_valid ? w_head.result      : '0;
  assign cdb_npc         = cdb_valid ? w_head.npc         : '0;
  assign cdb_take_branch = cdb_valid && w_head.take_branch;
  assign cdb_dest_valid  = cdb_valid && w_head_writes;
  assign cdb_dest_tag    = cdb_dest_valid ? w_head.dest_tag : '0;
  assign cdb_rob_idx     = cdb_valid ? w_head.rob_idx     : '0;
  assign cdb_halt        = cdb_valid && w_head.halt;
  assign cdb_illegal     = cdb_valid && w_head.illegal;
  assign count           = r_count;

endmodule
`default_nettype wire
